// File: rtl/ctrl_resolve_unit.sv
// ctrl_resolve_unit: branch checkpoint tracking, resolve/squash handling and post-mispredict recovery window
module ctrl_resolve_unit #(
  parameter int CHECKPOINTS     = 4,
  parameter int CHECKPOINTS_LOG = $clog2(CHECKPOINTS),
  parameter int SIZE_PC         = 32,
  parameter int SIZE_CTI_LOG    = 4,
  parameter int RECOVER_CYCLES  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       allocReq_i,
  output logic                       allocReady_o,
  output logic [CHECKPOINTS_LOG-1:0] allocId_o,
  output logic [CHECKPOINTS-1:0]     branchMask_o,
  input  logic                       ctrlVerified_i,
  input  logic                       ctrlMispredict_i,
  input  logic                       ctrlConditional_i,
  input  logic [CHECKPOINTS_LOG-1:0] ctrlSMTid_i,
  input  logic [SIZE_PC-1:0]         ctrlTargetAddr_i,
  input  logic                       ctrlBrDirection_i,
  input  logic [SIZE_CTI_LOG-1:0]    ctrlCtiQueueIndex_i,
  output logic                       redirectValid_o,
  output logic [SIZE_PC-1:0]         redirectAddr_o,
  output logic [CHECKPOINTS-1:0]     flushMask_o,
  output logic                       updateValid_o,
  output logic [SIZE_CTI_LOG-1:0]    updateCtiIndex_o,
  output logic                       updateDirection_o,
  output logic                       updateConditional_o,
  output logic                       recovering_o,
  output logic                       ctrlError_o
);
  typedef enum logic {IDLE, RECOVER} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [CHECKPOINTS-1:0] live, live_nx, squashed, squashed_nx, squash, kmask, free_dep;
  logic [CHECKPOINTS-1:0] dep [CHECKPOINTS];
  logic accept, hit_mis, hit_ok, grant, err_set;
  assign kmask   = CHECKPOINTS'(1) << ctrlSMTid_i;
  assign accept  = ctrlVerified_i & live[ctrlSMTid_i];
  assign hit_mis = accept & ctrlMispredict_i;
  assign hit_ok  = accept & ~ctrlMispredict_i;
  assign allocReady_o = (state == IDLE) & ~&live & ~(ctrlVerified_i & ctrlMispredict_i);
  assign grant   = allocReq_i & allocReady_o;
  assign branchMask_o = live;
  assign recovering_o = state == RECOVER;
  // squashed ids stay exempt from the error flag until the recovery window closes
  assign err_set = ctrlVerified_i & ~live[ctrlSMTid_i] & ~(recovering_o & squashed[ctrlSMTid_i]);
  always_comb begin
    allocId_o = '0;
    for (int i = CHECKPOINTS - 1; i >= 0; i--)
      if (!live[i]) allocId_o = CHECKPOINTS_LOG'(i);
  end
  always_comb begin
    squash = kmask;
    for (int i = 0; i < CHECKPOINTS; i++)
      if (live[i] && dep[i][ctrlSMTid_i]) squash[i] = 1'b1;
  end
  always_comb begin
    free_dep    = live & ~(hit_ok ? kmask : '0);
    live_nx     = live & ~(hit_mis ? squash : hit_ok ? kmask : '0)
                | (grant ? CHECKPOINTS'(1) << allocId_o : '0);
    squashed_nx = hit_mis ? (recovering_o ? squashed | squash : squash) : squashed;
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (hit_mis) begin
      state_nx = RECOVER;
      cnt_nx   = 4'(RECOVER_CYCLES);
    end else if (state == RECOVER) begin
      state_nx = (cnt == 4'd1) ? IDLE : RECOVER;
      cnt_nx   = cnt - 4'd1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      live                <= '0;
      squashed            <= '0;
      for (int i = 0; i < CHECKPOINTS; i++) dep[i] <= '0;
      ctrlError_o         <= 1'b0;
      redirectValid_o     <= 1'b0;
      redirectAddr_o      <= '0;
      flushMask_o         <= '0;
      updateValid_o       <= 1'b0;
      updateCtiIndex_o    <= '0;
      updateDirection_o   <= 1'b0;
      updateConditional_o <= 1'b0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      live            <= live_nx;
      squashed        <= squashed_nx;
      for (int i = 0; i < CHECKPOINTS; i++)
        dep[i] <= (grant && allocId_o == CHECKPOINTS_LOG'(i)) ? free_dep
                : dep[i] & ~(accept ? kmask : '0);
      ctrlError_o     <= ctrlError_o | err_set;
      redirectValid_o <= hit_mis;
      updateValid_o   <= accept;
      if (hit_mis) begin
        redirectAddr_o <= ctrlTargetAddr_i;
        flushMask_o    <= squash;
      end
      if (accept) begin
        updateCtiIndex_o    <= ctrlCtiQueueIndex_i;
        updateDirection_o   <= ctrlBrDirection_i;
        updateConditional_o <= ctrlConditional_i;
      end
    end
  end
endmodule

// File: tb/tb_ctrl_resolve_unit.sv
// tb_ctrl_resolve_unit: directed plus random checks against an allocation-order queue model
module tb_ctrl_resolve_unit;
  localparam int CP = 4;
  localparam int RC = 2;
  logic clk = 0, reset = 1;
  logic alloc_req = 0, ver = 0, mis = 0, cond = 0, dir = 0;
  logic [1:0] sid = '0;
  logic [31:0] tgt = '0;
  logic [3:0] cti = '0;
  logic alloc_ready, redirect_valid, update_valid, update_dir, update_cond, recovering, ctrl_error;
  logic [1:0] alloc_id;
  logic [3:0] branch_mask, flush_mask, update_cti;
  logic [31:0] redirect_addr;
  int errors = 0, checks = 0;
  int q[$];
  bit err_m;
  int rcnt;
  bit [3:0] sq;

  always #5 clk = ~clk;

  ctrl_resolve_unit #(.CHECKPOINTS(CP), .SIZE_PC(32), .SIZE_CTI_LOG(4), .RECOVER_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .allocReq_i(alloc_req), .allocReady_o(alloc_ready),
    .allocId_o(alloc_id), .branchMask_o(branch_mask), .ctrlVerified_i(ver),
    .ctrlMispredict_i(mis), .ctrlConditional_i(cond), .ctrlSMTid_i(sid),
    .ctrlTargetAddr_i(tgt), .ctrlBrDirection_i(dir), .ctrlCtiQueueIndex_i(cti),
    .redirectValid_o(redirect_valid), .redirectAddr_o(redirect_addr), .flushMask_o(flush_mask),
    .updateValid_o(update_valid), .updateCtiIndex_o(update_cti), .updateDirection_o(update_dir),
    .updateConditional_o(update_cond), .recovering_o(recovering), .ctrlError_o(ctrl_error));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pos_of(input int id);
    foreach (q[i]) if (q[i] == id) return i;
    return -1;
  endfunction

  function automatic bit [3:0] live_mask();
    bit [3:0] m = '0;
    foreach (q[i]) m[q[i]] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    err_m = 0;
    rcnt = 0;
    sq = '0;
  endtask

  task automatic step(input bit req_v, ver_v, mis_v, cond_v, dir_v, input int id,
                      input logic [31:0] tgt_v, input logic [3:0] cti_v);
    bit ready, acc;
    int aid, pos;
    bit [3:0] fl;
    alloc_req = req_v; ver = ver_v; mis = mis_v; cond = cond_v; dir = dir_v;
    sid = 2'(id); tgt = tgt_v; cti = cti_v;
    #1;
    ready = rcnt == 0 && q.size() < CP && !(ver_v && mis_v);
    aid = 0;
    for (int i = CP - 1; i >= 0; i--) if (pos_of(i) < 0) aid = i;
    check("alloc_ready", 32'(alloc_ready), 32'(ready));
    if (q.size() < CP) check("alloc_id", 32'(alloc_id), 32'(aid));
    pos = pos_of(id);
    acc = ver_v && pos >= 0;
    if (ver_v && pos < 0 && !(rcnt > 0 && sq[id])) err_m = 1;
    fl = '0;
    if (acc && mis_v) begin
      for (int i = pos; i < q.size(); i++) fl[q[i]] = 1'b1;
      while (q.size() > pos) void'(q.pop_back());
      sq = (rcnt > 0) ? (sq | fl) : fl;
      rcnt = RC;
    end else begin
      if (rcnt > 0) rcnt--;
      if (acc) q.delete(pos);
    end
    if (req_v && ready) q.push_back(aid);
    @(posedge clk);
    #1;
    check("branch_mask", 32'(branch_mask), 32'(live_mask()));
    check("recovering", 32'(recovering), 32'(rcnt > 0));
    check("ctrl_error", 32'(ctrl_error), 32'(err_m));
    check("update_valid", 32'(update_valid), 32'(acc));
    check("redirect_valid", 32'(redirect_valid), 32'(acc && mis_v));
    if (acc) begin
      check("update_cti", 32'(update_cti), 32'(cti_v));
      check("update_dir", 32'(update_dir), 32'(dir_v));
      check("update_cond", 32'(update_cond), 32'(cond_v));
    end
    if (acc && mis_v) begin
      check("redirect_addr", redirect_addr, tgt_v);
      check("flush_mask", 32'(flush_mask), 32'(fl));
    end
  endtask

  task automatic idle_step(input bit req_v);
    step(req_v, 0, 0, 0, 0, 0, 32'h0, 4'h0);
  endtask

  task automatic resolve(input int id, input bit mis_v, input logic [31:0] tgt_v);
    step(0, 1, mis_v, 1, 1, id, tgt_v, 4'(id + 5));
  endtask

  task automatic do_reset();
    alloc_req = 0; ver = 0; mis = 0;
    #2 reset = 1;
    #1;
    check("rst_branch_mask", 32'(branch_mask), 0);
    check("rst_alloc_id", 32'(alloc_id), 0);
    check("rst_recovering", 32'(recovering), 0);
    check("rst_error", 32'(ctrl_error), 0);
    check("rst_redirect", 32'({redirect_valid, flush_mask}), 0);
    check("rst_redirect_addr", redirect_addr, 0);
    check("rst_update", 32'({update_valid, update_cti, update_dir, update_cond}), 0);
    model_reset();
    #2 reset = 0;
    #1;
    check("rst_alloc_ready", 32'(alloc_ready), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #12 reset = 0;
    #1 check("init_alloc_ready", 32'(alloc_ready), 1);
    @(posedge clk);
    #1;
    repeat (4) idle_step(1);
    idle_step(1);
    resolve(2, 0, 32'h0);
    idle_step(1);
    do_reset();
    repeat (3) idle_step(1);
    step(1, 1, 1, 1, 0, 0, 32'h1000, 4'h3);
    repeat (3) idle_step(1);
    do_reset();
    repeat (3) idle_step(1);
    resolve(1, 0, 32'h0);
    resolve(2, 1, 32'h2222);
    do_reset();
    repeat (4) idle_step(1);
    step(1, 1, 0, 0, 1, 0, 32'h0, 4'h9);
    idle_step(1);
    step(1, 1, 1, 0, 0, 3, 32'h3300, 4'h2);
    repeat (3) idle_step(1);
    do_reset();
    resolve(3, 0, 32'h0);
    idle_step(0);
    do_reset();
    repeat (3) idle_step(1);
    resolve(0, 1, 32'h4000);
    resolve(1, 0, 32'h0);
    resolve(2, 1, 32'h0);
    idle_step(0);
    do_reset();
    repeat (3) idle_step(1);
    resolve(2, 1, 32'h5000);
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      else step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, $urandom_range(0, 2) == 0,
                1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom, 4'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ctrl_resolve_unit.md
# ctrl_resolve_unit

Branch-resolution and checkpoint manager. It consumes the control-verify packet that writeback drives each cycle: verified, mispredict, checkpoint id, target, direction, CTI index and conditional flag. It tracks live branch checkpoints, hands out free checkpoints to rename, frees them on resolution, and on a mispredict emits a squash mask and a fetch redirect. It then holds allocation off for a fixed recovery window. It sits between writeback and the rename/fetch front end.

## Interface

Parameters:
- CHECKPOINTS, 4: number of branch checkpoints. CHECKPOINTS_LOG = log2(CHECKPOINTS).
- SIZE_PC, 32: PC width.
- SIZE_CTI_LOG, 4: CTI-queue index width.
- RECOVER_CYCLES, 2: allocation-blocked cycles after a mispredict. Must be 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- allocReq_i  in  1  rename requests one checkpoint.
- allocReady_o  out  1  a checkpoint can be granted this cycle.
- allocId_o  out  CHECKPOINTS_LOG  granted id: lowest-index free checkpoint.
- branchMask_o  out  CHECKPOINTS  registered live-checkpoint mask, attached by rename to new instructions.
- ctrlVerified_i  in  1  resolve packet valid.
- ctrlMispredict_i  in  1  resolved branch mispredicted.
- ctrlConditional_i  in  1  branch is conditional.
- ctrlSMTid_i  in  CHECKPOINTS_LOG  checkpoint id being resolved.
- ctrlTargetAddr_i  in  SIZE_PC  correct target.
- ctrlBrDirection_i  in  1  actual direction.
- ctrlCtiQueueIndex_i  in  SIZE_CTI_LOG  CTI-queue entry.
- redirectValid_o  out  1  one-cycle fetch redirect pulse.
- redirectAddr_o  out  SIZE_PC  redirect target.
- flushMask_o  out  CHECKPOINTS  checkpoints squashed, valid with redirectValid_o.
- updateValid_o  out  1  one-cycle predictor-update pulse.
- updateCtiIndex_o  out  SIZE_CTI_LOG  CTI index for the update.
- updateDirection_o  out  1  direction for the update.
- updateConditional_o  out  1  conditional flag for the update.
- recovering_o  out  1  FSM in RECOVER.
- ctrlError_o  out  1  sticky flag: a resolve named a non-live checkpoint.

## Operation

State:
- live[CHECKPOINTS]: one bit per checkpoint.
- dep[i][CHECKPOINTS]: live mask captured when checkpoint i was allocated, i.e. its older checkpoints.
- FSM state: IDLE or RECOVER.
- recovery counter.

A resolve is accepted when ctrlVerified_i=1 and live[ctrlSMTid_i]=1.
- A resolve on a non-live id is ignored and sets ctrlError_o.
- During RECOVER, a resolve on a squashed id hits a non-live id and is dropped silently. It does not set ctrlError_o.

Correct resolve (mispredict=0), id k:
- Clear live[k].
- Clear bit k in every dep[i].
- Register updateValid_o and the update fields.

Mispredict resolve, id k:
- squash = {k} ∪ {i : live[i] & dep[i][k]}.
- Clear live for every id in squash.
- Clear bit k in the surviving dep entries.
- Register redirectValid_o=1, redirectAddr_o=target, flushMask_o=squash.
- Also issue the predictor update.
- FSM goes to RECOVER with counter = RECOVER_CYCLES.

Allocation:
- allocReady_o = (state==IDLE) & (live != all-ones) & ~(ctrlVerified_i & ctrlMispredict_i). This term is combinational.
- A grant is allocReq_i & allocReady_o.
- On a grant: live[allocId_o] <= 1 and dep[allocId_o] <= live minus any id correctly resolved in the same cycle.
- An id freed in cycle N is not granted in cycle N, because allocId_o is computed from registered live.

FSM:
- IDLE -> RECOVER on an accepted mispredict.
- In RECOVER the counter decrements each cycle. RECOVER -> IDLE when the counter reaches 1.
- A further accepted mispredict in RECOVER reloads the counter and issues a new redirect and squash.

## Timing

- Reset (asynchronous) values:
  - live=0, dep=0, state=IDLE, ctrlError_o=0.
  - All pulse outputs 0, redirectAddr_o=0, flushMask_o=0, update fields 0.
  - branchMask_o=0, allocId_o=0.
  - allocReady_o=1 once reset is released.
- A resolve sampled at edge N drives redirect and update outputs in cycle N+1, for exactly one cycle.
- live, branchMask_o and the recovering_o rise update at edge N.
- recovering_o stays high for exactly RECOVER_CYCLES cycles after the mispredict edge.
- All outputs except allocReady_o are registered.
- Reset asserted mid-RECOVER returns the block to IDLE immediately and drops any pending pulses.

## Test plan

- Four allocs in back-to-back cycles give ids 0,1,2,3 and branchMask_o=1111. Then allocReady_o=0. A correct resolve of id 2 gives updateValid_o pulse 1 cycle later and branchMask_o=1011. The next alloc grants id 2.
- Allocate 0,1,2 in order, then mispredict id 0 with target 0x1000. Required response, next cycle: redirectValid_o=1, redirectAddr_o=0x1000, flushMask_o=0111. After that, branchMask_o=0000 and allocReady_o=0 for 2 cycles.
- Allocate 0,1,2, correct-resolve id 1, then mispredict id 2. Required: flushMask_o=0100 and live=0001.
- allocReq_i in the same cycle as a mispredict gives no grant. allocReq_i in the same cycle as a correct resolve of id 0 (all four live) gives no grant, since the full mask is registered. The next cycle grants id 0.
- A resolve of non-live id 3 sets ctrlError_o and it stays set. Squashed ids resolved during RECOVER leave ctrlError_o=0.
- reset pulsed during RECOVER with live=0011 gives all outputs at their reset values asynchronously, state IDLE, allocReady_o=1 after release.
